home_cmd_uart_rx: RTL and testbench



---
 rtl/home_auto_pkg.sv | 29 ++
 rtl/home_sync_2ff.sv | 23 ++
 rtl/home_cmd_uart_rx.sv | 130 +++++++++++++
 tb/tb_home_cmd_uart_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/home_auto_pkg.sv
// Shared constants for the smart-home command path: mode codes, wake nibble
// and the rx FSM state encoding.
package home_auto_pkg;

   localparam logic [3:0] MODE_LIGHT_ON   = 4'd0;
   localparam logic [3:0] MODE_LIGHT_OFF  = 4'd1;
   localparam logic [3:0] MODE_FAN_ON     = 4'd2;
   localparam logic [3:0] MODE_FAN_OFF    = 4'd3;
   localparam logic [3:0] MODE_AC_ON      = 4'd4;
   localparam logic [3:0] MODE_AC_OFF     = 4'd5;
   localparam logic [3:0] MODE_HEATER_ON  = 4'd6;
   localparam logic [3:0] MODE_HEATER_OFF = 4'd7;
   localparam logic [3:0] MODE_WM_ON      = 4'd8;
   localparam logic [3:0] MODE_WM_OFF     = 4'd9;
   localparam logic [3:0] MODE_ALARM_ON   = 4'd10;
   localparam logic [3:0] MODE_ALARM_OFF  = 4'd11;

   // Wake keyword expected in data bits [7:4]
   localparam logic [3:0] SYNC_NIBBLE_DEFAULT = 4'hA;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_ISSUE
   } rx_state_t;

endpackage

// File: rtl/home_sync_2ff.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle-high
// line level so reset release never looks like a start bit.
module home_sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/home_cmd_uart_rx.sv
// 8N1 UART command receiver: validates wake nibble, mode range and stop bit,
// then emits a one-cycle ok_google strobe with a held mode code, or frame_err.
module home_cmd_uart_rx
   import home_auto_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter logic [3:0]  SYNC_NIBBLE  = SYNC_NIBBLE_DEFAULT,
   parameter logic [3:0]  MAX_MODE     = 4'd11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       ok_google,
   output logic [3:0] mode,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

   rx_state_t        state, state_next;
   logic             rx_s;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       data;
   logic             stop_bit;
   logic             rearm;

   logic             cnt_clr;
   logic             shift;
   logic             stop_smp;
   logic             issue_ok;
   logic             issue_err;

   home_sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RX_IDLE;
      else     state <= state_next;
   end

   // Next-state and per-cycle control strobes
   always_comb begin
      state_next = state;
      cnt_clr    = 1'b0;
      shift      = 1'b0;
      stop_smp   = 1'b0;
      issue_ok   = 1'b0;
      issue_err  = 1'b0;
      unique case (state)
         RX_IDLE: begin
            if (!rx_s && rearm) begin
               state_next = RX_START;
               cnt_clr    = 1'b1;
            end
         end
         RX_START: begin
            if (cnt == HALF_END) begin
               cnt_clr    = 1'b1;
               state_next = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt == BIT_END) begin
               cnt_clr = 1'b1;
               shift   = 1'b1;
               if (bit_idx == 3'd7) state_next = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt == BIT_END) begin
               cnt_clr    = 1'b1;
               stop_smp   = 1'b1;
               state_next = RX_ISSUE;
            end
         end
         RX_ISSUE: begin
            state_next = RX_IDLE;
            if (stop_bit && (data[7:4] == SYNC_NIBBLE) && (data[3:0] <= MAX_MODE))
               issue_ok = 1'b1;
            else
               issue_err = 1'b1;
         end
         default: state_next = RX_IDLE;
      endcase
   end

   // Datapath: bit timing, shift register, registered outputs and rearm guard
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         bit_idx   <= '0;
         data      <= '0;
         stop_bit  <= 1'b0;
         ok_google <= 1'b0;
         frame_err <= 1'b0;
         mode      <= '0;
         busy      <= 1'b0;
         rearm     <= 1'b1;
      end else begin
         if (cnt_clr || state == RX_IDLE || state == RX_ISSUE) cnt <= '0;
         else                                                  cnt <= cnt + 1'b1;

         if (state == RX_IDLE) bit_idx <= '0;
         else if (shift)       bit_idx <= bit_idx + 1'b1;

         if (shift)    data     <= {rx_s, data[7:1]};
         if (stop_smp) stop_bit <= rx_s;

         ok_google <= issue_ok;
         frame_err <= issue_err;
         if (issue_ok) mode <= data[3:0];
         busy <= (state_next != RX_IDLE);

         // A low line at ISSUE (break) must go high before a new start is accepted
         if (state == RX_ISSUE)                              rearm <= rx_s;
         else if (rx_s)                                      rearm <= 1'b1;
         else if (state == RX_IDLE && state_next == RX_START) rearm <= 1'b0;
      end
   end

endmodule

// File: tb/tb_home_cmd_uart_rx.sv
// Self-checking bench for home_cmd_uart_rx: table vectors, corner sequences
// and random frames judged by a frame-level reference model.
module tb_home_cmd_uart_rx;
   import home_auto_pkg::*;

   localparam int unsigned CPB = 16;
   // 2 synchroniser cycles + 1 detect cycle before IDLE->START, then the frame latency
   localparam int LAT = 3 + CPB / 2 + 9 * CPB + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       ok_google;
   logic       frame_err;
   logic       busy;
   logic [3:0] mode;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   int         ok_cyc_q[$];
   logic [3:0] ok_mode_q[$];
   int         err_cyc_q[$];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_ok;
      logic [3:0] exp_mode;
   } vec_t;

   vec_t       vecs[9];
   logic [3:0] model_mode;

   home_cmd_uart_rx #(
      .CLKS_PER_BIT (CPB),
      .SYNC_NIBBLE  (4'hA),
      .MAX_MODE     (4'd11)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .ok_google (ok_google),
      .mode      (mode),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse recorder and mutual-exclusion check
   always @(negedge clk) begin
      if (ok_google) begin
         ok_cyc_q.push_back(cyc);
         ok_mode_q.push_back(mode);
      end
      if (frame_err) err_cyc_q.push_back(cyc);
      if (ok_google || frame_err) begin
         checks++;
         if (ok_google && frame_err) begin
            errors++;
            $display("FAIL excl: ok_google and frame_err both high at cycle %0d", cyc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      ok_cyc_q.delete();
      ok_mode_q.delete();
      err_cyc_q.delete();
   endtask

   task automatic send(input logic [7:0] b, input logic stop, output int c0);
      rx = 1'b0;
      c0 = cyc;
      repeat (CPB) tick();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) tick();
      end
      rx = stop;
      repeat (CPB) tick();
      rx = 1'b1;
   endtask

   task automatic expect_frame(input string name, input int c0, input logic exp_ok,
                               input logic [3:0] exp_mode);
      while (cyc < c0 + LAT + 4) tick();
      check({name, "_ok_cnt"}, ok_cyc_q.size(), exp_ok ? 1 : 0);
      check({name, "_err_cnt"}, err_cyc_q.size(), exp_ok ? 0 : 1);
      if (exp_ok && ok_cyc_q.size() > 0) begin
         check({name, "_ok_lat"}, ok_cyc_q[0] - c0, LAT);
         check({name, "_ok_mode"}, int'(ok_mode_q[0]), int'(exp_mode));
      end
      if (!exp_ok && err_cyc_q.size() > 0)
         check({name, "_err_lat"}, err_cyc_q[0] - c0, LAT);
      check({name, "_held_mode"}, int'(mode), int'(exp_mode));
      check({name, "_busy"}, int'(busy), 0);
      clear_q();
   endtask

   function automatic logic model_valid(input logic [7:0] b, input logic stop);
      return stop && (b[7:4] == SYNC_NIBBLE_DEFAULT) && (int'(b[3:0]) <= 11);
   endfunction

   initial begin
      int         c0;
      int         c1;
      logic [7:0] b;
      logic       stop;
      logic       valid;

      vecs[0] = '{8'hA4, 1'b1, 1'b1, MODE_AC_ON};
      vecs[1] = '{8'h54, 1'b1, 1'b0, MODE_AC_ON};
      vecs[2] = '{8'hAC, 1'b1, 1'b0, MODE_AC_ON};
      vecs[3] = '{8'hA0, 1'b0, 1'b0, MODE_AC_ON};
      vecs[4] = '{8'hA1, 1'b1, 1'b1, MODE_LIGHT_OFF};
      vecs[5] = '{8'hAB, 1'b1, 1'b1, MODE_ALARM_OFF};
      vecs[6] = '{8'hA0, 1'b1, 1'b1, MODE_LIGHT_ON};
      vecs[7] = '{8'hB5, 1'b1, 1'b0, MODE_LIGHT_ON};
      vecs[8] = '{8'hAF, 1'b1, 1'b0, MODE_LIGHT_ON};

      // Reset state
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) tick();
      check("rst_ok", int'(ok_google), 0);
      check("rst_err", int'(frame_err), 0);
      check("rst_mode", int'(mode), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b0;
      repeat (4) tick();
      check("post_rst_busy", int'(busy), 0);
      clear_q();
      model_mode = 4'd0;

      // Table vectors
      for (int v = 0; v < 9; v++) begin
         send(vecs[v].data, vecs[v].stop, c0);
         expect_frame($sformatf("vec%0d", v), c0, vecs[v].exp_ok, vecs[v].exp_mode);
         repeat (4) tick();
      end
      model_mode = vecs[8].exp_mode;

      // Short glitch: busy rises then falls, no pulse
      rx = 1'b0;
      c0 = cyc;
      repeat (3) tick();
      rx = 1'b1;
      repeat (2) tick();
      check("glitch_busy_hi", int'(busy), 1);
      while (cyc < c0 + 30) tick();
      check("glitch_busy_lo", int'(busy), 0);
      check("glitch_pulses", ok_cyc_q.size() + err_cyc_q.size(), 0);
      clear_q();

      // Back-to-back frames with no idle gap
      send(8'hA2, 1'b1, c0);
      send(8'hA3, 1'b1, c1);
      while (cyc < c1 + LAT + 4) tick();
      check("b2b_ok_cnt", ok_cyc_q.size(), 2);
      check("b2b_err_cnt", err_cyc_q.size(), 0);
      if (ok_cyc_q.size() == 2) begin
         check("b2b_lat", ok_cyc_q[0] - c0, LAT);
         check("b2b_gap", ok_cyc_q[1] - ok_cyc_q[0], 10 * CPB);
         check("b2b_mode0", int'(ok_mode_q[0]), 2);
         check("b2b_mode1", int'(ok_mode_q[1]), 3);
      end
      model_mode = 4'd3;
      clear_q();
      repeat (4) tick();

      // Break: line held low gives one frame_err and no re-trigger while low
      rx = 1'b0;
      c0 = cyc;
      repeat (220) tick();
      check("break_err_cnt", err_cyc_q.size(), 1);
      check("break_ok_cnt", ok_cyc_q.size(), 0);
      if (err_cyc_q.size() > 0) check("break_err_lat", err_cyc_q[0] - c0, LAT);
      check("break_busy", int'(busy), 0);
      check("break_mode", int'(mode), int'(model_mode));
      rx = 1'b1;
      repeat (6) tick();
      clear_q();

      // Random frames against the frame-level model
      for (int k = 0; k < 24; k++) begin
         b = 8'($urandom);
         if ($urandom_range(0, 1) == 1) b[7:4] = 4'hA;
         stop  = ($urandom_range(0, 9) != 0);
         valid = model_valid(b, stop);
         if (valid) model_mode = b[3:0];
         send(b, stop, c0);
         expect_frame($sformatf("rnd%0d_%02h_%0d", k, b, stop), c0, valid, model_mode);
         repeat ($urandom_range(2, 10)) tick();
      end

      // Reset during data bit 4 of 0xA6 aborts the frame at once
      b  = 8'hA6;
      rx = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         repeat (CPB) tick();
      end
      rx = b[4];
      repeat (8) tick();
      rst = 1'b1;
      #1;
      check("midrst_ok", int'(ok_google), 0);
      check("midrst_err", int'(frame_err), 0);
      check("midrst_mode", int'(mode), 0);
      check("midrst_busy", int'(busy), 0);
      rx = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (200) tick();
      check("midrst_pulses", ok_cyc_q.size() + err_cyc_q.size(), 0);
      clear_q();
      model_mode = 4'd0;
      send(8'hA8, 1'b1, c0);
      expect_frame("after_rst", c0, 1'b1, MODE_WM_ON);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
